// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register with a ready/valid load handshake, LSB first.
// Define PISO_SHIFT_PARITY_EN to append an even-parity bit as the last frame cycle.
module piso_shift_register #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
`ifdef PISO_SHIFT_PARITY_EN
   localparam int unsigned LastIdx = WIDTH;
`else
   localparam int unsigned LastIdx = WIDTH - 1;
`endif
   localparam logic [CntW-1:0] LastCnt = CntW'(LastIdx);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              last_bit;
   logic              accept;
`ifdef PISO_SHIFT_PARITY_EN
   logic              parity_q, parity_d;
`endif

   // Outputs decode registered state only, so clear never reaches them combinationally.
   assign last_bit     = (state_q == StShift) && (cnt_q == LastCnt);
   assign load_ready   = (state_q == StIdle) || last_bit;
   assign accept       = load_valid && load_ready;
   assign busy         = (state_q == StShift);
   assign serial_valid = (state_q == StShift);
   assign done         = last_bit;

`ifdef PISO_SHIFT_PARITY_EN
   assign serial_out = busy && (last_bit ? parity_q : shift_q[0]);
`else
   assign serial_out = busy && shift_q[0];
`endif

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
`ifdef PISO_SHIFT_PARITY_EN
      parity_d = parity_q;
`endif
      if (accept) begin
         state_d  = StShift;
         shift_d  = data_in;
         cnt_d    = '0;
`ifdef PISO_SHIFT_PARITY_EN
         parity_d = ^data_in;
`endif
      end else if (state_q == StShift) begin
         if (last_bit) begin
            state_d = StIdle;
            shift_d = '0;
            cnt_d   = '0;
         end else begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q  <= StIdle;
         shift_q  <= '0;
         cnt_q    <= '0;
`ifdef PISO_SHIFT_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
`ifdef PISO_SHIFT_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register (WIDTH=8); frame length follows PISO_SHIFT_PARITY_EN.
// Observed vector per cycle is {serial_out, serial_valid, busy, done, load_ready}.
module tb_piso_shift_register;

`ifdef PISO_SHIFT_PARITY_EN
   localparam int Frame = 9;
`else
   localparam int Frame = 8;
`endif

   logic       clock = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       load_valid = 1'b0;
   logic       load_ready, serial_out, serial_valid, busy, done;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [4:0] IdleVec = 5'b00001;

   piso_shift_register #(.WIDTH(8)) dut (
      .clock        (clock),
      .clear        (clear),
      .data_in      (data_in),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .busy         (busy),
      .done         (done)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      clear = 1'b1;
      step();
      step();
      clear = 1'b0;
      obs = {serial_out, serial_valid, busy, done, load_ready};
      n_cmp++;
      if (obs !== IdleVec) begin
         n_err++;
         $display("FAIL reset: got %b want %b", obs, IdleVec);
      end
   endtask

   // 0xA5 from idle; data_in is scrambled after accept to prove single sampling.
   task automatic test_single();
      logic [8:0] seq = 9'b0_1010_0101;  // seq[k] = bit on frame cycle k, [8] = parity
      logic [4:0] obs, exp;
      data_in = 8'hA5;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      data_in = 8'h5A;
      for (int k = 0; k < Frame; k++) begin
         obs = {serial_out, serial_valid, busy, done, load_ready};
         exp = {seq[k], 1'b1, 1'b1, k == Frame - 1, k == Frame - 1};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL single_a5 cycle %0d: got %b want %b", k, obs, exp);
         end
         step();
      end
      obs = {serial_out, serial_valid, busy, done, load_ready};
      n_cmp++;
      if (obs !== IdleVec) begin
         n_err++;
         $display("FAIL single_a5 end: got %b want %b", obs, IdleVec);
      end
   endtask

   // 0x3C then 0xC3 offered on the last cycle: no gap between frames.
   task automatic test_back_to_back();
      logic [17:0] seq = {1'b0, 8'hC3, 1'b0, 8'h3C};
      logic [4:0]  obs, exp;
      logic        bit_exp;
      data_in = 8'h3C;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < Frame; k++) begin
            bit_exp = (k == 8) ? seq[f * 9 + 8] : seq[f * 9 + k];
            obs = {serial_out, serial_valid, busy, done, load_ready};
            exp = {bit_exp, 1'b1, 1'b1, k == Frame - 1, k == Frame - 1};
            n_cmp++;
            if (obs !== exp) begin
               n_err++;
               $display("FAIL back_to_back frame %0d cycle %0d: got %b want %b", f, k, obs, exp);
            end
            if (f == 0 && k == Frame - 1) begin
               data_in = 8'hC3;
               load_valid = 1'b1;
            end
            step();
            load_valid = 1'b0;
         end
      end
      obs = {serial_out, serial_valid, busy, done, load_ready};
      n_cmp++;
      if (obs !== IdleVec) begin
         n_err++;
         $display("FAIL back_to_back end: got %b want %b", obs, IdleVec);
      end
   endtask

   // 0xFF offered mid-frame of 0x00 must be ignored.
   task automatic test_ignore_busy();
      logic [4:0] obs, exp;
      data_in = 8'h00;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int k = 0; k < Frame; k++) begin
         obs = {serial_out, serial_valid, busy, done, load_ready};
         exp = {1'b0, 1'b1, 1'b1, k == Frame - 1, k == Frame - 1};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL ignore_busy cycle %0d: got %b want %b", k, obs, exp);
         end
         if (k == 3) begin
            data_in = 8'hFF;
            load_valid = 1'b1;
         end
         step();
         load_valid = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
         obs = {serial_out, serial_valid, busy, done, load_ready};
         n_cmp++;
         if (obs !== IdleVec) begin
            n_err++;
            $display("FAIL ignore_busy idle %0d: got %b want %b", k, obs, IdleVec);
         end
         step();
      end
   endtask

   // clear during bit 5 of 0xFF abandons the frame with no done pulse.
   task automatic test_clear_mid_frame();
      logic [4:0] obs, exp;
      data_in = 8'hFF;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         obs = {serial_out, serial_valid, busy, done, load_ready};
         exp = 5'b11100;
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL clear_mid cycle %0d: got %b want %b", k, obs, exp);
         end
         if (k == 5) clear = 1'b1;
         step();
         clear = 1'b0;
      end
      for (int k = 0; k < Frame; k++) begin
         obs = {serial_out, serial_valid, busy, done, load_ready};
         n_cmp++;
         if (obs !== IdleVec) begin
            n_err++;
            $display("FAIL clear_mid after %0d: got %b want %b", k, obs, IdleVec);
         end
         step();
      end
   endtask

   // 0x07: three ones then zeros; odd popcount gives parity 1 when enabled.
   task automatic test_parity();
      logic [8:0] seq = 9'b1_0000_0111;
      logic [4:0] obs, exp;
      data_in = 8'h07;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int k = 0; k < Frame; k++) begin
         obs = {serial_out, serial_valid, busy, done, load_ready};
         exp = {seq[k], 1'b1, 1'b1, k == Frame - 1, k == Frame - 1};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL parity_07 cycle %0d: got %b want %b", k, obs, exp);
         end
         step();
      end
      obs = {serial_out, serial_valid, busy, done, load_ready};
      n_cmp++;
      if (obs !== IdleVec) begin
         n_err++;
         $display("FAIL parity_07 end: got %b want %b", obs, IdleVec);
      end
   endtask

   // clear and load_valid together: clear wins, nothing captured.
   task automatic test_clear_vs_load();
      logic [4:0] obs;
      data_in = 8'hFF;
      load_valid = 1'b1;
      clear = 1'b1;
      step();
      load_valid = 1'b0;
      clear = 1'b0;
      for (int k = 0; k < 3; k++) begin
         obs = {serial_out, serial_valid, busy, done, load_ready};
         n_cmp++;
         if (obs !== IdleVec) begin
            n_err++;
            $display("FAIL clear_vs_load cycle %0d: got %b want %b", k, obs, IdleVec);
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_ignore_busy();
      test_clear_mid_frame();
      test_parity();
      test_clear_vs_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
